// File: rtl/pcs_pkg.sv
// Shared state encoding, K28.5 patterns and comma masks for the 1000BASE-X receive synchronizer.
package pcs_pkg;

  typedef enum logic [3:0] {
    LOSS_OF_SYNC,
    COMMA_DETECT_1,
    COMMA_DETECT_2,
    COMMA_DETECT_3,
    ACQUIRE_SYNC_1,
    ACQUIRE_SYNC_2,
    SYNC_ACQUIRED_1,
    SYNC_ACQUIRED_2,
    SYNC_ACQUIRED_2A,
    SYNC_ACQUIRED_3,
    SYNC_ACQUIRED_3A,
    SYNC_ACQUIRED_4,
    SYNC_ACQUIRED_4A
  } sync_state_e;

  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  // Both comma polarities, compared against code-group bits [9:3].
  localparam logic [6:0] COMMA_MASK_RDN = 7'b0011111;
  localparam logic [6:0] COMMA_MASK_RDP = 7'b1100000;

  function automatic logic is_sync_acquired(input sync_state_e s);
    return (s == SYNC_ACQUIRED_1)  || (s == SYNC_ACQUIRED_2)  ||
           (s == SYNC_ACQUIRED_2A) || (s == SYNC_ACQUIRED_3)  ||
           (s == SYNC_ACQUIRED_3A) || (s == SYNC_ACQUIRED_4)  ||
           (s == SYNC_ACQUIRED_4A);
  endfunction

  function automatic logic is_comma_detect(input sync_state_e s);
    return (s == COMMA_DETECT_1) || (s == COMMA_DETECT_2) || (s == COMMA_DETECT_3);
  endfunction

  function automatic logic is_acquire_sync(input sync_state_e s);
    return (s == ACQUIRE_SYNC_1) || (s == ACQUIRE_SYNC_2);
  endfunction

  // One level deeper into error recovery; the fourth level gives up sync.
  function automatic sync_state_e sa_worse(input sync_state_e s);
    case (s)
      SYNC_ACQUIRED_1:                   return SYNC_ACQUIRED_2;
      SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A: return SYNC_ACQUIRED_3;
      SYNC_ACQUIRED_3, SYNC_ACQUIRED_3A: return SYNC_ACQUIRED_4;
      default:                           return LOSS_OF_SYNC;
    endcase
  endfunction

  function automatic sync_state_e sa_better(input sync_state_e s);
    case (s)
      SYNC_ACQUIRED_3A: return SYNC_ACQUIRED_2;
      SYNC_ACQUIRED_4A: return SYNC_ACQUIRED_3;
      default:          return SYNC_ACQUIRED_1;
    endcase
  endfunction

  function automatic sync_state_e sa_to_a(input sync_state_e s);
    case (s)
      SYNC_ACQUIRED_3: return SYNC_ACQUIRED_3A;
      SYNC_ACQUIRED_4: return SYNC_ACQUIRED_4A;
      default:         return SYNC_ACQUIRED_2A;
    endcase
  endfunction

endpackage

// File: rtl/pcs_cg_check.sv
// Combinational code-group checker: comma detect, popcount, disparity validity and next running disparity.
module pcs_cg_check
  import pcs_pkg::*;
(
  input  logic [9:0] cg_i,
  input  logic       rd_pos_i,
  output logic       comma_o,
  output logic       cg_good_o,
  output logic       rd_pos_next_o
);

  logic [3:0] ones;

  always_comb begin
    ones = '0;
    for (int i = 0; i < 10; i++) begin
      ones = ones + {3'b000, cg_i[i]};
    end
  end

  assign comma_o = (cg_i[9:3] == COMMA_MASK_RDN) || (cg_i[9:3] == COMMA_MASK_RDP);

  // A 6-ones group is only legal from RD-, a 4-ones group only from RD+.
  assign cg_good_o = (ones == 4'd5) ||
                     ((ones == 4'd6) && !rd_pos_i) ||
                     ((ones == 4'd4) &&  rd_pos_i);

  always_comb begin
    rd_pos_next_o = rd_pos_i;
    if (ones == 4'd6) begin
      rd_pos_next_o = 1'b1;
    end else if (ones == 4'd4) begin
      rd_pos_next_o = 1'b0;
    end
  end

endmodule

// File: rtl/pcs_rx_sync.sv
// 1000BASE-X PCS receive code-group synchronizer (IEEE 802.3 Clause 36 sync FSM).
// Optional saturating error counter enabled by defining PCS_SYNC_ERR_CNT_EN.
module pcs_rx_sync
  import pcs_pkg::*;
#(
  parameter int GOOD_CGS = 4
`ifdef PCS_SYNC_ERR_CNT_EN
  , parameter int ERR_CNT_W = 16
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       power,
  input  logic [9:0] rx_code_group,
  output logic       RX_EVEN,
  output logic       code_sync_status,
  output logic [9:0] sync_code_group,
  output logic       rd_pos
`ifdef PCS_SYNC_ERR_CNT_EN
  , output logic [ERR_CNT_W-1:0] err_count
`endif
);

  localparam int CNT_W = $clog2(GOOD_CGS + 1);

  sync_state_e      state_q, state_d;
  logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
  logic             rx_even_q, rx_even_d;
  logic             status_q, status_d;
  logic             rd_q, rd_d;
  logic [9:0]       cg_q;

  logic comma;
  logic cg_good_raw;
  logic rd_next_good;
  logic even_slot;
  logic cg_bad;

  pcs_cg_check u_cg_check (
    .cg_i          (rx_code_group),
    .rd_pos_i      (rd_q),
    .comma_o       (comma),
    .cg_good_o     (cg_good_raw),
    .rd_pos_next_o (rd_next_good)
  );

  assign even_slot = !rx_even_q;

  // Once alignment is being tracked, a comma on an odd slot means misalignment.
  assign cg_bad = !cg_good_raw ||
                  (comma && !even_slot &&
                   (is_acquire_sync(state_q) || is_sync_acquired(state_q)));

  assign rd_d = cg_bad ? rd_q : rd_next_good;

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    rx_even_d  = even_slot;

    case (state_q)
      LOSS_OF_SYNC: begin
        if (comma) state_d = COMMA_DETECT_1;
      end
      COMMA_DETECT_1: state_d = (!cg_bad && !comma) ? ACQUIRE_SYNC_1  : LOSS_OF_SYNC;
      COMMA_DETECT_2: state_d = (!cg_bad && !comma) ? ACQUIRE_SYNC_2  : LOSS_OF_SYNC;
      COMMA_DETECT_3: state_d = (!cg_bad && !comma) ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
      ACQUIRE_SYNC_1: begin
        if (cg_bad)     state_d = LOSS_OF_SYNC;
        else if (comma) state_d = COMMA_DETECT_2;
      end
      ACQUIRE_SYNC_2: begin
        if (cg_bad)     state_d = LOSS_OF_SYNC;
        else if (comma) state_d = COMMA_DETECT_3;
      end
      SYNC_ACQUIRED_1: begin
        if (cg_bad) state_d = SYNC_ACQUIRED_2;
      end
      SYNC_ACQUIRED_2, SYNC_ACQUIRED_3, SYNC_ACQUIRED_4: begin
        if (cg_bad) begin
          state_d = sa_worse(state_q);
        end else begin
          state_d    = sa_to_a(state_q);
          good_cnt_d = CNT_W'(1);
        end
      end
      SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4A: begin
        if (cg_bad) begin
          state_d = sa_worse(state_q);
        end else if (good_cnt_q == CNT_W'(GOOD_CGS - 1)) begin
          state_d    = sa_better(state_q);
          good_cnt_d = '0;
        end else begin
          good_cnt_d = good_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = LOSS_OF_SYNC;
    endcase

    if (!power) begin
      state_d = LOSS_OF_SYNC;
    end

    // The comma that opens a COMMA_DETECT state defines the even slot.
    if (is_comma_detect(state_d)) begin
      rx_even_d = 1'b1;
    end

    status_d = is_sync_acquired(state_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= LOSS_OF_SYNC;
      good_cnt_q <= '0;
      rx_even_q  <= 1'b0;
      status_q   <= 1'b0;
      rd_q       <= 1'b0;
      cg_q       <= '0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      rx_even_q  <= rx_even_d;
      status_q   <= status_d;
      rd_q       <= rd_d;
      cg_q       <= rx_code_group;
    end
  end

  assign RX_EVEN          = rx_even_q;
  assign code_sync_status = status_q;
  assign sync_code_group  = cg_q;
  assign rd_pos           = rd_q;

`ifdef PCS_SYNC_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (status_q && cg_bad && (err_q != '1)) begin
      err_d = err_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_pcs_rx_sync.sv
// Directed self-checking bench for pcs_rx_sync; err_count scenario included when PCS_SYNC_ERR_CNT_EN is defined.
module tb_pcs_rx_sync;
  import pcs_pkg::*;

  localparam logic [9:0] D16_2 = 10'b1001000101;
  localparam logic [9:0] D21_5 = 10'b1010101010;
  localparam logic [9:0] BAD   = 10'b1111111111;

  logic       clock;
  logic       reset;
  logic       power;
  logic [9:0] rx_code_group;
  logic       RX_EVEN;
  logic       code_sync_status;
  logic [9:0] sync_code_group;
  logic       rd_pos;
`ifdef PCS_SYNC_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  int checks;
  int errors;

  pcs_rx_sync #(.GOOD_CGS(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .power            (power),
    .rx_code_group    (rx_code_group),
    .RX_EVEN          (RX_EVEN),
    .code_sync_status (code_sync_status),
    .sync_code_group  (sync_code_group),
    .rd_pos           (rd_pos)
`ifdef PCS_SYNC_ERR_CNT_EN
    , .err_count      (err_count)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Drive one group for one clock and return 1 time unit after the edge.
  task automatic sendGroup(input logic [9:0] cg, input logic pwr);
    rx_code_group = cg;
    power         = pwr;
    @(posedge clock);
    #1;
  endtask

  task automatic resetDut();
    reset         = 1'b1;
    power         = 1'b1;
    rx_code_group = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Six idle groups, K28.5 first, starting from RD-.
  task automatic syncUp();
    for (int i = 0; i < 6; i++) begin
      sendGroup((i % 2 == 0) ? K28_5_RDN : D16_2, 1'b1);
    end
  endtask

  task automatic test_reset();
    rx_code_group = K28_5_RDN;
    resetDut();
    checks++;
    if ({RX_EVEN, code_sync_status, rd_pos, sync_code_group} !== 13'b0) begin
      errors++;
      $display("[TB] FAIL reset_values got even=%b sync=%b rd=%b cg=%b want all zero",
               RX_EVEN, code_sync_status, rd_pos, sync_code_group);
    end
  endtask

  task automatic test_acquire();
    logic [9:0] cg;
    logic       expStatus;
    logic       expAlt;
    resetDut();
    for (int i = 0; i < 8; i++) begin
      cg = (i % 2 == 0) ? K28_5_RDN : D16_2;
      sendGroup(cg, 1'b1);
      expStatus = (i >= 5);
      expAlt    = (i % 2 == 0);
      checks++;
      if (code_sync_status !== expStatus) begin
        errors++;
        $display("[TB] FAIL acquire_status[%0d] got %b want %b", i, code_sync_status, expStatus);
      end
      checks++;
      if (RX_EVEN !== expAlt) begin
        errors++;
        $display("[TB] FAIL acquire_rx_even[%0d] got %b want %b", i, RX_EVEN, expAlt);
      end
      checks++;
      if (rd_pos !== expAlt) begin
        errors++;
        $display("[TB] FAIL acquire_rd_pos[%0d] got %b want %b", i, rd_pos, expAlt);
      end
      checks++;
      if (sync_code_group !== cg) begin
        errors++;
        $display("[TB] FAIL acquire_cg[%0d] got %b want %b", i, sync_code_group, cg);
      end
    end
  endtask

  // One bad group then four good ones: SA_2 -> SA_2A -> back to SA_1.
  task automatic test_single_error();
    resetDut();
    syncUp();
    sendGroup(BAD, 1'b1);
    checks++;
    if ({code_sync_status, RX_EVEN, rd_pos, sync_code_group} !== {1'b1, 1'b1, 1'b0, BAD}) begin
      errors++;
      $display("[TB] FAIL single_err_bad got sync=%b even=%b rd=%b cg=%b want 1 1 0 %b",
               code_sync_status, RX_EVEN, rd_pos, sync_code_group, BAD);
    end
    for (int i = 0; i < 4; i++) begin
      sendGroup(D21_5, 1'b1);
      checks++;
      if (code_sync_status !== 1'b1) begin
        errors++;
        $display("[TB] FAIL single_err_recover[%0d] got %b want 1", i, code_sync_status);
      end
    end
  endtask

  // Continues from SA_1: four bad groups with short gaps walk SA_2..SA_4 and lose sync.
  task automatic test_multi_error();
    logic [9:0] seq [9];
    logic       expStatus;
    seq = '{BAD, D21_5, D21_5, BAD, D21_5, D21_5, BAD, D21_5, BAD};
    for (int i = 0; i < 9; i++) begin
      sendGroup(seq[i], 1'b1);
      expStatus = (i < 8);
      checks++;
      if (code_sync_status !== expStatus) begin
        errors++;
        $display("[TB] FAIL multi_err_status[%0d] got %b want %b", i, code_sync_status, expStatus);
      end
    end
  endtask

  // K, D, D, K puts the second comma on an odd slot in ACQUIRE_SYNC_1.
  task automatic test_odd_comma();
    logic [9:0] cg;
    logic       expStatus;
    resetDut();
    sendGroup(K28_5_RDN, 1'b1);
    sendGroup(D16_2, 1'b1);
    sendGroup(D21_5, 1'b1);
    sendGroup(K28_5_RDN, 1'b1);
    checks++;
    if ({code_sync_status, RX_EVEN, rd_pos} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL odd_comma_bad got sync=%b even=%b rd=%b want 0 0 0",
               code_sync_status, RX_EVEN, rd_pos);
    end
    // From LOSS_OF_SYNC a full six-group acquisition is required.
    for (int i = 0; i < 6; i++) begin
      cg = (i % 2 == 0) ? K28_5_RDN : D16_2;
      sendGroup(cg, 1'b1);
      expStatus = (i == 5);
      checks++;
      if (code_sync_status !== expStatus) begin
        errors++;
        $display("[TB] FAIL odd_comma_resync[%0d] got %b want %b", i, code_sync_status, expStatus);
      end
    end
  endtask

  task automatic test_power();
    logic expStatus;
    resetDut();
    syncUp();
    checks++;
    if (code_sync_status !== 1'b1) begin
      errors++;
      $display("[TB] FAIL power_presync got %b want 1", code_sync_status);
    end
    sendGroup(D21_5, 1'b0);
    checks++;
    if ({code_sync_status, rd_pos} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL power_drop got sync=%b rd=%b want 0 0", code_sync_status, rd_pos);
    end
    for (int i = 0; i < 6; i++) begin
      sendGroup((i % 2 == 0) ? K28_5_RDN : D16_2, 1'b1);
      expStatus = (i == 5);
      checks++;
      if (code_sync_status !== expStatus) begin
        errors++;
        $display("[TB] FAIL power_resync[%0d] got %b want %b", i, code_sync_status, expStatus);
      end
    end
  endtask

  task automatic test_reset_mid_acquire();
    logic expStatus;
    resetDut();
    sendGroup(K28_5_RDN, 1'b1);
    sendGroup(D16_2, 1'b1);
    sendGroup(K28_5_RDN, 1'b1);
    sendGroup(D16_2, 1'b1);
    rx_code_group = K28_5_RDN;
    resetDut();
    checks++;
    if ({RX_EVEN, code_sync_status, rd_pos, sync_code_group} !== 13'b0) begin
      errors++;
      $display("[TB] FAIL midreset_values got even=%b sync=%b rd=%b cg=%b want all zero",
               RX_EVEN, code_sync_status, rd_pos, sync_code_group);
    end
    for (int i = 0; i < 6; i++) begin
      sendGroup((i % 2 == 0) ? K28_5_RDN : D16_2, 1'b1);
      expStatus = (i == 5);
      checks++;
      if (code_sync_status !== expStatus) begin
        errors++;
        $display("[TB] FAIL midreset_resync[%0d] got %b want %b", i, code_sync_status, expStatus);
      end
    end
  endtask

`ifdef PCS_SYNC_ERR_CNT_EN
  task automatic test_err_count();
    resetDut();
    sendGroup(BAD, 1'b1);
    syncUp();
    checks++;
    if (err_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL errcnt_presync got %0d want 0", err_count);
    end
    for (int n = 0; n < 3; n++) begin
      sendGroup(BAD, 1'b1);
      for (int i = 0; i < 4; i++) sendGroup(D21_5, 1'b1);
    end
    checks++;
    if ({code_sync_status, err_count} !== {1'b1, 16'd3}) begin
      errors++;
      $display("[TB] FAIL errcnt_three got sync=%b cnt=%0d want 1 3", code_sync_status, err_count);
    end
    resetDut();
    checks++;
    if ({err_count, RX_EVEN, code_sync_status, rd_pos, sync_code_group} !== 29'b0) begin
      errors++;
      $display("[TB] FAIL errcnt_reset got cnt=%0d even=%b sync=%b rd=%b cg=%b want all zero",
               err_count, RX_EVEN, code_sync_status, rd_pos, sync_code_group);
    end
  endtask
`endif

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    power         = 1'b1;
    rx_code_group = '0;
    test_reset();
    test_acquire();
    test_single_error();
    test_multi_error();
    test_odd_comma();
    test_power();
    test_reset_mid_acquire();
`ifdef PCS_SYNC_ERR_CNT_EN
    test_err_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
